// File: rtl/rotate_seq_unit_if.sv
// Start/done handshake and operand/result bundle for the multi-cycle rotate/shift engine.
// master = execution sequencer, slave = rotate_seq_unit.
interface rotate_seq_unit_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [CNT_W-1:0] count;
    logic [2:0]       op;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] R;
    logic             CF;
    logic             OF;

    modport master (
        output start, A, count, op, cin,
        input  busy, done, R, CF, OF
    );

    modport slave (
        input  start, A, count, op, cin,
        output busy, done, R, CF, OF
    );
endinterface

// File: rtl/rotate_seq_unit.sv
// One-bit-per-clock ROL/ROR/RCL/RCR/SHL/SHR/SAR engine with start/done handshake.
// Optional ROT_COUNT_MASK_EN reduces the step count up front to shorten latency.
//
// state  | meaning
// IDLE   | waiting for start; operands latched on an accepted start
// RUN    | one step per clock on {c, r} until remaining count reaches zero
// DONE   | one-cycle done pulse; R/CF/OF already hold the result
module rotate_seq_unit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input logic               clk,
    input logic               rst,
    rotate_seq_unit_if.slave  bus
);
    localparam int M = WIDTH - 1;

    localparam logic [2:0] OP_ROL = 3'b000;
    localparam logic [2:0] OP_ROR = 3'b001;
    localparam logic [2:0] OP_RCL = 3'b010;
    localparam logic [2:0] OP_RCR = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_SAL = 3'b110;
    localparam logic [2:0] OP_SAR = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_q, step_r, res_r;
    logic             c_q, step_c, res_c, res_of;
    logic [2:0]       op_q;
    logic             msb0_q;
    logic [CNT_W-1:0] rem_q, n_eff;

`ifdef ROT_COUNT_MASK_EN
    // Rotates repeat with period WIDTH (WIDTH+1 through carry); shifts saturate past WIDTH+1.
    always_comb begin
        n_eff = bus.count;
        case (bus.op)
            OP_ROL, OP_ROR: n_eff = CNT_W'(int'(bus.count) % WIDTH);
            OP_RCL, OP_RCR: n_eff = CNT_W'(int'(bus.count) % (WIDTH + 1));
            default: if (int'(bus.count) > WIDTH + 1) n_eff = CNT_W'(WIDTH + 1);
        endcase
    end
`else
    assign n_eff = bus.count;
`endif

    always_comb begin
        step_r = r_q;
        step_c = c_q;
        case (op_q)
            OP_ROL: begin step_r = {r_q[M-1:0], r_q[M]}; step_c = r_q[M]; end
            OP_ROR: begin step_r = {r_q[0], r_q[M:1]};   step_c = r_q[0]; end
            OP_RCL: {step_c, step_r} = {r_q, c_q};
            OP_RCR: {step_r, step_c} = {c_q, r_q};
            OP_SHL, OP_SAL: begin step_r = {r_q[M-1:0], 1'b0}; step_c = r_q[M]; end
            OP_SHR: begin step_r = {1'b0, r_q[M:1]};     step_c = r_q[0]; end
            OP_SAR: begin step_r = {r_q[M], r_q[M:1]};   step_c = r_q[0]; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = (n_eff == '0) ? S_DONE : S_RUN;
            S_RUN:   if (rem_q == CNT_W'(1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Result registers load only on the edge entering DONE, so they stay stable between operations.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= '0;
            c_q    <= 1'b0;
            op_q   <= '0;
            msb0_q <= 1'b0;
            rem_q  <= '0;
            res_r  <= '0;
            res_c  <= 1'b0;
            res_of <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.start) begin
                    r_q    <= bus.A;
                    c_q    <= bus.cin;
                    op_q   <= bus.op;
                    msb0_q <= bus.A[M];
                    rem_q  <= n_eff;
                    if (n_eff == '0) begin
                        res_r  <= bus.A;
                        res_c  <= bus.cin;
                        res_of <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_q   <= step_r;
                    c_q   <= step_c;
                    rem_q <= rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        res_r  <= step_r;
                        res_c  <= step_c;
                        res_of <= msb0_q ^ step_r[M];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.busy = (state_q != S_IDLE);
        bus.done = (state_q == S_DONE);
        bus.R    = res_r;
        bus.CF   = res_c;
        bus.OF   = res_of;
    end
endmodule

// File: tb/tb_rotate_seq_unit.sv
// Self-checking bench for rotate_seq_unit: directed vectors, random ops against a
// whole-count arithmetic model, busy-time start rejection, mid-run reset, back-to-back.
module tb_rotate_seq_unit;
    localparam int W  = 16;
    localparam int CW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rotate_seq_unit_if #(.WIDTH(W), .CNT_W(CW)) bus ();
    rotate_seq_unit #(.WIDTH(W), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [2:0]   d_op  [6] = '{3'd0, 3'd3, 3'd2, 3'd7, 3'd5, 3'd1};
    logic [W-1:0] d_a   [6] = '{16'h8001, 16'h0001, 16'h1234, 16'h8000, 16'hFFFF, 16'hABCD};
    int           d_cnt [6] = '{1, 1, 17, 15, 20, 0};
    logic         d_ci  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [W-1:0] d_r   [6] = '{16'h0003, 16'h0000, 16'h1234, 16'hFFFF, 16'h0000, 16'hABCD};
    logic         d_cf  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic         d_of  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`ifdef ROT_COUNT_MASK_EN
    int           d_lat [6] = '{2, 2, 1, 16, 18, 1};
`else
    int           d_lat [6] = '{2, 2, 18, 16, 21, 1};
`endif

    // Whole-count reference: rotates as modular rotation, shifts as plain arithmetic shifts.
    function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic ci,
                                  input int cnt, output logic [W-1:0] r, output logic c,
                                  output logic o, output int lat);
        int n;
        int k;
        longint unsigned v;
        longint s;
        n = cnt;
`ifdef ROT_COUNT_MASK_EN
        if (op == 3'd0 || op == 3'd1)      n = cnt % W;
        else if (op == 3'd2 || op == 3'd3) n = cnt % (W + 1);
        else if (cnt > W + 1)              n = W + 1;
`endif
        lat = n + 1;
        v = longint'(a);
        c = ci;
        case (op)
            3'd0: begin k = n % W; v = ((v << k) | (v >> (W - k))) & 64'hFFFF; if (n > 0) c = v[0]; end
            3'd1: begin k = n % W; v = ((v >> k) | (v << (W - k))) & 64'hFFFF; if (n > 0) c = v[W-1]; end
            3'd2: begin
                v = v | (longint'(ci) << W);
                k = n % (W + 1);
                v = ((v << k) | (v >> (W + 1 - k))) & 64'h1FFFF;
                c = v[W];
            end
            3'd3: begin
                v = v | (longint'(ci) << W);
                k = n % (W + 1);
                v = ((v >> k) | (v << (W + 1 - k))) & 64'h1FFFF;
                c = v[W];
            end
            3'd4, 3'd6: begin
                v = (v << n) & 64'hFFFF;
                if (n >= 1 && n <= W) c = a[W-n];
                else if (n > W)       c = 1'b0;
            end
            3'd5: begin
                v = v >> n;
                if (n >= 1 && n <= W) c = a[n-1];
                else if (n > W)       c = 1'b0;
            end
            default: begin
                s = longint'($signed(a));
                s = s >>> n;
                v = longint'(s) & 64'hFFFF;
                if (n >= 1 && n <= W) c = a[n-1];
                else if (n > W)       c = a[W-1];
            end
        endcase
        r = v[W-1:0];
        o = a[W-1] ^ r[W-1];
    endfunction

    // Issues one start and waits for done; lat = edges from acceptance to done (-1 on timeout).
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input int cnt,
                          input logic ci, output int lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.count = CW'(cnt);
        bus.cin   = ci;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.A     = W'($urandom);
        lat = 1;
        while (bus.done !== 1'b1 && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (bus.done !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
        checks++; if (bus.R !== '0) begin errors++; $display("FAIL reset_R got %h exp 0000", bus.R); end
        checks++; if (bus.CF !== 1'b0) begin errors++; $display("FAIL reset_CF got %b exp 0", bus.CF); end
        checks++; if (bus.OF !== 1'b0) begin errors++; $display("FAIL reset_OF got %b exp 0", bus.OF); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        int lat;
        logic [W-1:0] held;
        for (int i = 0; i < 6; i++) begin
            run_op(d_op[i], d_a[i], d_cnt[i], d_ci[i], lat);
            checks++; if (lat !== d_lat[i]) begin errors++; $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, d_lat[i]); end
            checks++; if (bus.R !== d_r[i]) begin errors++; $display("FAIL dir%0d_R got %h exp %h", i, bus.R, d_r[i]); end
            checks++; if (bus.CF !== d_cf[i]) begin errors++; $display("FAIL dir%0d_CF got %b exp %b", i, bus.CF, d_cf[i]); end
            checks++; if (bus.OF !== d_of[i]) begin errors++; $display("FAIL dir%0d_OF got %b exp %b", i, bus.OF, d_of[i]); end
            held = bus.R;
            @(posedge clk);
            #1;
            checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL dir%0d_pulse got done=%b busy=%b exp 0 0", i, bus.done, bus.busy); end
            checks++; if (bus.R !== held) begin errors++; $display("FAIL dir%0d_hold got %h exp %h", i, bus.R, held); end
        end
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [W-1:0] a, er;
        logic ci, ec, eo;
        int cnt, lat, elat;
        for (int i = 0; i < 60; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = W'($urandom);
            cnt = $urandom_range(0, 31);
            ci  = 1'($urandom);
            model(op, a, ci, cnt, er, ec, eo, elat);
            run_op(op, a, cnt, ci, lat);
            checks++; if (lat !== elat) begin errors++; $display("FAIL rand%0d_latency op=%0d cnt=%0d got %0d exp %0d", i, op, cnt, lat, elat); end
            checks++; if (bus.R !== er) begin errors++; $display("FAIL rand%0d_R op=%0d a=%h cnt=%0d got %h exp %h", i, op, a, cnt, bus.R, er); end
            checks++; if (bus.CF !== ec) begin errors++; $display("FAIL rand%0d_CF op=%0d a=%h cnt=%0d got %b exp %b", i, op, a, cnt, bus.CF, ec); end
            checks++; if (bus.OF !== eo) begin errors++; $display("FAIL rand%0d_OF op=%0d a=%h cnt=%0d got %b exp %b", i, op, a, cnt, bus.OF, eo); end
            @(posedge clk);
            #1;
            checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rand%0d_pulse got done=%b exp 0", i, bus.done); end
        end
    endtask

    task automatic test_busy_ignore();
        logic [W-1:0] er, got_r;
        logic ec, eo;
        int elat, pulses, first;
        model(3'd1, 16'h1357, 1'b0, 5, er, ec, eo, elat);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd1; bus.A = 16'h1357; bus.count = CW'(5); bus.cin = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_rise got %b exp 1", bus.busy); end
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd4; bus.A = 16'hFFFF; bus.count = CW'(2); bus.cin = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b0;
        pulses = 0; first = -1; got_r = '0;
        for (int t = 3; t <= 16; t++) begin
            if (bus.done === 1'b1) begin
                pulses++;
                if (first < 0) begin first = t; got_r = bus.R; end
            end
            @(posedge clk);
            #1;
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL busy_pulses got %0d exp 1", pulses); end
        checks++; if (first !== elat) begin errors++; $display("FAIL busy_latency got %0d exp %0d", first, elat); end
        checks++; if (got_r !== er) begin errors++; $display("FAIL busy_R got %h exp %h", got_r, er); end
    endtask

    task automatic test_mid_reset();
        logic [W-1:0] a, er;
        logic ec, eo;
        int lat, elat, pulses;
        a = W'($urandom) | 16'h8001;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd0; bus.A = a; bus.count = CW'(8); bus.cin = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b exp 0", bus.done); end
        checks++; if (bus.R !== '0) begin errors++; $display("FAIL midrst_R got %h exp 0000", bus.R); end
        checks++; if (bus.CF !== 1'b0 || bus.OF !== 1'b0) begin errors++; $display("FAIL midrst_flags got CF=%b OF=%b exp 0 0", bus.CF, bus.OF); end
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int t = 0; t < 12; t++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_nodone got %0d pulses exp 0", pulses); end
        model(3'd0, a, 1'b0, 8, er, ec, eo, elat);
        run_op(3'd0, a, 8, 1'b0, lat);
        checks++; if (lat !== elat) begin errors++; $display("FAIL midrst_relat got %0d exp %0d", lat, elat); end
        checks++; if (bus.R !== er || bus.CF !== ec || bus.OF !== eo) begin
            errors++; $display("FAIL midrst_rerun got %h/%b/%b exp %h/%b/%b", bus.R, bus.CF, bus.OF, er, ec, eo);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [2:0] op;
        logic [W-1:0] a, er;
        logic ec, eo;
        int cnt, lat, elat, c1, c2;
        run_op(3'd2, 16'hC3A5, 3, 1'b1, lat);
        c1 = cyc;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b%0d_idle got busy=%b exp 0", i, bus.busy); end
            op  = 3'($urandom_range(0, 7));
            a   = W'($urandom);
            cnt = $urandom_range(0, 9);
            model(op, a, 1'b0, cnt, er, ec, eo, elat);
            run_op(op, a, cnt, 1'b0, lat);
            c2 = cyc;
            checks++; if (c2 - c1 !== elat + 1) begin errors++; $display("FAIL b2b%0d_period got %0d exp %0d", i, c2 - c1, elat + 1); end
            checks++; if (bus.R !== er || bus.CF !== ec || bus.OF !== eo) begin
                errors++; $display("FAIL b2b%0d_result got %h/%b/%b exp %h/%b/%b", i, bus.R, bus.CF, bus.OF, er, ec, eo);
            end
            c1 = c2;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.A     = '0;
        bus.count = '0;
        bus.op    = '0;
        bus.cin   = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
